// File: rtl/acc_cpu.sv
// Parametrised accumulator CPU: FETCH/EXEC/HALT sequencer with a req/ack fetch
// port, a flagged ALU, an internal register file and conditional jumps.
module acc_cpu #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4,
  parameter int NREG   = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_run,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [WIDTH+3:0]  i_imem_data,
  output logic [WIDTH-1:0]  o_acc,
  output logic              o_zero,
  output logic              o_carry,
  output logic [WIDTH-1:0]  o_out_data,
  output logic              o_out_valid,
  output logic [1:0]        o_state,
  output logic              o_halted
);

  localparam int KW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_LDI = 4'h1, OP_LDR = 4'h2, OP_STR = 4'h3, OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9, OP_SHL = 4'hA, OP_OUT = 4'hB, OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [WIDTH+3:0]   r_ir;
  logic [WIDTH-1:0]   r_acc;
  logic               r_zero;
  logic               r_carry;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_halted;
  logic [WIDTH-1:0]   r_regs [NREG];

  logic [3:0]         w_op;
  logic [WIDTH-1:0]   w_operand;
  logic [KW-1:0]      w_k;
  logic [WIDTH-1:0]   w_rk;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_zero_next;
  logic               w_carry_next;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_reg_we;
  logic [WIDTH:0]     w_sum;
  logic               w_fetch_hit;

  assign w_op      = r_ir[WIDTH+3:WIDTH];
  assign w_operand = r_ir[WIDTH-1:0];
  assign w_k       = w_operand[KW-1:0];
  assign w_rk      = r_regs[w_k];

  // Sequencer: the fetch request is the only combinational output.
  always_comb begin
    w_state_next = r_state;
    o_imem_req   = 1'b0;
    w_fetch_hit  = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req  = i_run;
        w_fetch_hit = i_run & i_imem_ack;
        if (w_fetch_hit) w_state_next = S_EXEC;
      end
      S_EXEC:  w_state_next = (w_op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_acc_next   = r_acc;
    w_zero_next  = r_zero;
    w_carry_next = r_carry;
    w_pc_next    = r_pc + ADDR_W'(1);
    w_reg_we     = 1'b0;
    w_sum        = '0;
    case (w_op)
      OP_LDI: w_acc_next = w_operand;
      OP_LDR: w_acc_next = w_rk;
      OP_STR: w_reg_we   = 1'b1;
      OP_ADD: begin
        w_sum = {1'b0, r_acc} + {1'b0, w_rk};
        {w_carry_next, w_acc_next} = w_sum;
      end
      // The wrapped-out top bit of the subtraction is exactly the borrow.
      OP_SUB: begin
        w_sum = {1'b0, r_acc} - {1'b0, w_rk};
        {w_carry_next, w_acc_next} = w_sum;
      end
      OP_AND: w_acc_next = r_acc & w_rk;
      OP_OR:  w_acc_next = r_acc | w_rk;
      OP_XOR: w_acc_next = r_acc ^ w_rk;
      OP_NOT: w_acc_next = ~r_acc;
      OP_SHL: begin
        w_carry_next = r_acc[WIDTH-1];
        w_acc_next   = r_acc << 1;
      end
      OP_JMP: w_pc_next = w_operand[ADDR_W-1:0];
      OP_JZ:  if (r_zero)  w_pc_next = w_operand[ADDR_W-1:0];
      OP_JC:  if (r_carry) w_pc_next = w_operand[ADDR_W-1:0];
      default: ;
    endcase
    if (w_op == OP_LDI || w_op == OP_LDR || (w_op >= OP_ADD && w_op <= OP_SHL))
      w_zero_next = (w_acc_next == '0);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_acc       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= 1'b0;
      if (w_fetch_hit) r_ir <= i_imem_data;
      if (r_state == S_EXEC) begin
        r_acc   <= w_acc_next;
        r_zero  <= w_zero_next;
        r_carry <= w_carry_next;
        r_pc    <= w_pc_next;
        if (w_reg_we) r_regs[w_k] <= r_acc;
        if (w_op == OP_OUT) begin
          r_out_data  <= r_acc;
          r_out_valid <= 1'b1;
        end
        if (w_op == OP_HLT) r_halted <= 1'b1;
      end
    end
  end

  assign o_imem_addr = r_pc;
  assign o_acc       = r_acc;
  assign o_zero      = r_zero;
  assign o_carry     = r_carry;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_state     = r_state;
  assign o_halted    = r_halted;

endmodule
